mem_arbiter: RTL and testbench

Shares the single `mem` access port (ce/we/addr/width/data toward `mem` → `sram`) between N requesters, e.g. the `executor` and the packet ingress loader. It runs round-robin arbitration with a registered grant, a burst limit that forces rotation when others are waiting, and a mandatory one-cycle turnaround between owners. It sits between the requesters' `mem_*_o` ports and the `mem` block, replacing today's point-to-point connection.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus widths and arbiter state encoding for the mem port arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_BUS  = 32;
  localparam int DATA_BUS  = 32;
  localparam int WIDTH_BUS = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_TURN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting port after last, cyclically.
module rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    sel,
  output logic            valid
);

  int idx;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!valid && req[idx]) begin
        sel[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single mem access port: registered grant, burst
// limit with forced rotation, one TURN cycle between owners, sticky error flag.
//
// state    | meaning
// ARB_IDLE | no owner; pick next requester after last
// ARB_BUSY | owner holds gnt_o and drives the mem path
// ARB_TURN | bus idle for a cycle; last <= owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N         = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_i,
  output logic [N-1:0]          gnt_o,
  input  logic [N-1:0]          m_ce_i,
  input  logic [N-1:0]          m_we_i,
  input  logic [N*ADDR_BUS-1:0] m_addr_i,
  input  logic [N*WIDTH_BUS-1:0] m_width_i,
  input  logic [N*DATA_BUS-1:0] m_data_i,
  output logic [DATA_BUS-1:0]   m_data_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_BUS-1:0]   mem_addr_o,
  output logic [WIDTH_BUS-1:0]  mem_width_o,
  output logic [DATA_BUS-1:0]   mem_data_o,
  input  logic [DATA_BUS-1:0]   mem_data_i,
  output logic                  err_o
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAX_BURST);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  arb_state_t      state, state_n;
  logic [IDXW-1:0] owner, owner_n, last, last_n, pick_idx;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [N-1:0]    gnt_n, pick_sel;
  logic            pick_valid, owner_req, others_req, preempt;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req   (req_i),
    .last  (last),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N; k++)
      if (pick_sel[k]) pick_idx = IDXW'(k);
  end

  // gnt_o is one-hot(owner) throughout BUSY, so it doubles as the owner mask
  assign owner_req  = |(req_i & gnt_o);
  assign others_req = |(req_i & ~gnt_o);
  // >= lets a requester arriving after saturation still force rotation
  assign preempt    = (MAX_BURST != 0) && (cnt >= CNT_LAST) && others_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      last  <= IDXW'(N - 1);
      cnt   <= '0;
      gnt_o <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      gnt_o <= gnt_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    gnt_n   = gnt_o;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_n = pick_idx;
          gnt_n   = pick_sel;
          cnt_n   = '0;
          state_n = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if ((MAX_BURST != 0) && (cnt != CNT_MAX)) cnt_n = cnt + 1'b1;
        if (!owner_req || preempt) begin
          gnt_n   = '0;
          state_n = ARB_TURN;
        end
      end
      ARB_TURN: begin
        last_n  = owner;
        state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_ce_o    = FALSE;
    mem_we_o    = FALSE;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_o[k]) begin
        mem_ce_o    = m_ce_i[k];
        mem_we_o    = m_we_i[k];
        mem_addr_o  = m_addr_i[k*ADDR_BUS +: ADDR_BUS];
        mem_width_o = m_width_i[k*WIDTH_BUS +: WIDTH_BUS];
        mem_data_o  = m_data_i[k*DATA_BUS +: DATA_BUS];
      end
    end
  end

  assign m_data_o = mem_data_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= FALSE;
    else if (|(m_ce_i & ~gnt_o)) err_o <= TRUE;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: tenure-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int MB = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           req_i = '0;
  logic [N-1:0]           gnt_o;
  logic [N-1:0]           m_ce_i = '0;
  logic [N-1:0]           m_we_i = '0;
  logic [N*ADDR_BUS-1:0]  m_addr_i = '0;
  logic [N*WIDTH_BUS-1:0] m_width_i = '0;
  logic [N*DATA_BUS-1:0]  m_data_i = '0;
  logic [DATA_BUS-1:0]    m_data_o;
  logic                   mem_ce_o, mem_we_o;
  logic [ADDR_BUS-1:0]    mem_addr_o;
  logic [WIDTH_BUS-1:0]   mem_width_o;
  logic [DATA_BUS-1:0]    mem_data_o;
  logic [DATA_BUS-1:0]    mem_data_i = '0;
  logic                   err_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mem_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o),
    .m_ce_i(m_ce_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_width_i(m_width_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Word-addressed sram behind the mem port; read data lands after the edge.
  logic [DATA_BUS-1:0] sram [0:255];
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) sram[mem_addr_o[7:0]] <= mem_data_o;
      else          mem_data_i <= sram[mem_addr_o[7:0]];
    end
  end

  // Reference model: one owner at a time, tenure ends on release or after MB
  // granted cycles with someone else waiting, then two edges with no grant.
  int owner = -1;
  int last  = N - 1;
  int granted = 0;
  int gap = 0;
  bit merr = 1'b0;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1; last = N - 1; granted = 0; gap = 0; merr = 1'b0;
    end else begin
      logic [N-1:0] g;
      g = exp_gnt();
      if ((m_ce_i & ~g) != '0) merr = 1'b1;
      if (owner >= 0) begin
        granted++;
        if (!req_i[owner] || (MB != 0 && granted >= MB && (req_i & ~g) != '0)) begin
          last = owner; owner = -1; gap = 1;
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        for (int i = 1; i <= N; i++) begin
          int p;
          p = (last + i) % N;
          if (req_i[p]) begin owner = p; granted = 0; break; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt", 64'(gnt_o), 64'(exp_gnt()));
      check("err", 64'(err_o), 64'(merr));
      check("onehot", 64'($countones(gnt_o) <= 1), 64'(1));
      check("ce", 64'(mem_ce_o), (owner >= 0) ? 64'(m_ce_i[owner]) : 64'(0));
      check("we", 64'(mem_we_o), (owner >= 0) ? 64'(m_we_i[owner]) : 64'(0));
      check("addr", 64'(mem_addr_o), (owner >= 0) ? 64'(m_addr_i[owner*ADDR_BUS +: ADDR_BUS]) : 64'(0));
      check("width", 64'(mem_width_o), (owner >= 0) ? 64'(m_width_i[owner*WIDTH_BUS +: WIDTH_BUS]) : 64'(0));
      check("wdata", 64'(mem_data_o), (owner >= 0) ? 64'(m_data_i[owner*DATA_BUS +: DATA_BUS]) : 64'(0));
      check("rdata", 64'(m_data_o), 64'(mem_data_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic ce, input logic we,
                          input logic [ADDR_BUS-1:0] a, input logic [3:0] w,
                          input logic [DATA_BUS-1:0] d);
    m_ce_i[k] = ce;
    m_we_i[k] = we;
    m_addr_i[k*ADDR_BUS +: ADDR_BUS]    = a;
    m_width_i[k*WIDTH_BUS +: WIDTH_BUS] = w;
    m_data_i[k*DATA_BUS +: DATA_BUS]    = d;
  endtask

  task automatic do_reset(input logic [N-1:0] req_at_release);
    rst = 1'b1;
    req_i = '0;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    req_i = req_at_release;
    rst = 1'b0;
  endtask

  logic [N-1:0] trace [0:11];

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    tick();
    check("reset_gnt", 64'(gnt_o), 64'(0));
    check("reset_err", 64'(err_o), 64'(0));
    check("reset_ce", 64'(mem_ce_o), 64'(0));
    cmp_en = 1'b1;

    // single requester: write then read back 0xDEADBEEF at 128
    do_reset(2'b01);
    tick();
    check("single_gnt", 64'(gnt_o), 64'h1);
    set_port(0, 1, 1, 32'd128, 4'd4, 32'hDEADBEEF);
    tick();
    set_port(0, 1, 0, 32'd128, 4'd4, 32'h0);
    tick();
    check("sram_128", 64'(sram[128]), 64'hDEADBEEF);
    check("readback", 64'(m_data_o), 64'hDEADBEEF);
    set_port(0, 0, 0, 0, 0, 0);
    req_i = '0;
    repeat (3) tick();

    // simultaneous request, 3 granted cycles each
    begin
      int c0 = 0, c1 = 0;
      logic [N-1:0] exp_tr [0:9];
      exp_tr = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
      do_reset(2'b11);
      for (int i = 0; i < 10; i++) begin
        tick();
        trace[i] = gnt_o;
        if (gnt_o[0]) c0++;
        if (gnt_o[1]) c1++;
        if (c0 == 3) req_i[0] = 1'b0;
        if (c1 == 3) req_i[1] = 1'b0;
      end
      for (int i = 0; i < 10; i++) check($sformatf("simul_tr%0d", i), 64'(trace[i]), 64'(exp_tr[i]));
    end

    // burst limit: port 1 joins on cycle 2, port 0 preempted after MB cycles
    begin
      int c1 = 0, first0 = 0;
      bit first_done = 1'b0;
      logic [N-1:0] exp_tr [0:11];
      exp_tr = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
      do_reset(2'b01);
      for (int i = 0; i < 20; i++) begin
        tick();
        if (i < 12) trace[i] = gnt_o;
        if (i == 0) req_i[1] = 1'b1;
        if (gnt_o[0] && !first_done) first0++;
        if (gnt_o[1]) begin first_done = 1'b1; c1++; end
        if (c1 == 3) req_i[1] = 1'b0;
      end
      req_i[0] = 1'b0;
      check("burst_len", 64'(first0), 64'(MB));
      for (int i = 0; i < 12; i++) check($sformatf("burst_tr%0d", i), 64'(trace[i]), 64'(exp_tr[i]));
      repeat (3) tick();
    end

    // protocol violation: port 1 issues ce while port 0 owns the bus
    do_reset(2'b01);
    tick();
    set_port(0, 1, 0, 32'd128, 4'd4, 32'h0);
    set_port(1, 1, 1, 32'h40, 4'd4, 32'h12345678);
    #2;
    check("viol_addr", 64'(mem_addr_o), 64'd128);
    check("viol_err_before", 64'(err_o), 64'(0));
    tick();
    check("viol_err", 64'(err_o), 64'(1));
    set_port(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("viol_err_sticky", 64'(err_o), 64'(1));
    check("viol_sram_40", 64'(sram[8'h40]), 64'(0));

    // reset during port 0's write tenure
    set_port(0, 1, 1, 32'd200, 4'd4, 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    check("rst_gnt", 64'(gnt_o), 64'(0));
    check("rst_ce", 64'(mem_ce_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    tick();
    set_port(0, 0, 0, 0, 0, 0);
    req_i = 2'b11;
    rst = 1'b0;
    tick();
    check("rst_rewin", 64'(gnt_o), 64'h1);
    req_i = '0;
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
